simd_acc32: RTL and testbench

- Sequential vector accumulator that sits directly downstream of the 32-bit vector carry-propagate adder.
- Consumes a stream of packed 32-bit sums and accumulates a programmed number of beats, either as two independent signed 16-bit lanes or as one signed 32-bit lane.
- Presents the final accumulated word on a valid/ready output port.
- Used to close dot-product and row-reduction loops in the AI datapath.

---
 rtl/simd_acc_pkg.sv | 18 +
 rtl/vec_sat_add.sv | 44 ++++
 rtl/simd_acc32.sv | 93 +++++++++
 tb/tb_simd_acc32.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/simd_acc_pkg.sv
// Shared types and constants for the SIMD accumulator slice.
package simd_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic MODE_2X16 = 1'b0;
   localparam logic MODE_1X32 = 1'b1;

   localparam logic [15:0] SAT16_MAX = 16'h7FFF;
   localparam logic [15:0] SAT16_MIN = 16'h8000;
   localparam logic [31:0] SAT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/vec_sat_add.sv
// Lane-isolated signed adder with per-lane overflow detect and optional clamp.
module vec_sat_add
   import simd_acc_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mode,
   input  logic        sat_en,
   output logic [31:0] sum,
   output logic [1:0]  ovf
);

   logic [15:0] s0;
   logic [15:0] s1;
   logic [31:0] s32;
   logic        o0;
   logic        o1;
   logic        o32;

   // Raw lane sums and signed-overflow flags (same operand signs, result sign differs).
   always_comb begin
      s0  = a[15:0] + b[15:0];
      s1  = a[31:16] + b[31:16];
      s32 = a + b;
      o0  = (a[15] == b[15]) && (s0[15] != a[15]);
      o1  = (a[31] == b[31]) && (s1[15] != a[31]);
      o32 = (a[31] == b[31]) && (s32[31] != a[31]);
   end

   // Select lane packing, clamp toward the operand sign when saturating.
   always_comb begin
      sum = '0;
      ovf = '0;
      if (mode == MODE_2X16) begin
         sum[15:0]  = (sat_en && o0) ? (a[15] ? SAT16_MIN : SAT16_MAX) : s0;
         sum[31:16] = (sat_en && o1) ? (a[31] ? SAT16_MIN : SAT16_MAX) : s1;
         ovf        = {o1, o0};
      end else begin
         sum = (sat_en && o32) ? (a[31] ? SAT32_MIN : SAT32_MAX) : s32;
         ovf = {1'b0, o32};
      end
   end

endmodule

// File: rtl/simd_acc32.sv
// Beat-counting vector accumulator with valid/ready input and output ports.
module simd_acc32
   import simd_acc_pkg::*;
#(
   parameter int unsigned LEN_W = 8,
   parameter bit          SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [1:0]       ovf,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] rem;
   logic             mode_q;
   logic [31:0]      acc;
   logic [1:0]       ovf_q;
   logic [31:0]      sum;
   logic [1:0]       sum_ovf;
   logic             run_go;
   logic             beat;
   logic             last_beat;

   assign run_go    = (state == IDLE) && start && (len != '0);
   assign beat      = (state == ACC) && in_valid;
   assign last_beat = beat && (rem == LEN_W'(1));

   vec_sat_add u_add (
      .a      (acc),
      .b      (in_data),
      .mode   (mode_q),
      .sat_en (SAT),
      .sum    (sum),
      .ovf    (sum_ovf)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (run_go)              state_nxt = ACC;
         ACC:  if (last_beat)           state_nxt = OUT;
         OUT:  if (out_ready)           state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Run configuration, beat counter, accumulator and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem    <= '0;
         mode_q <= MODE_2X16;
         acc    <= '0;
         ovf_q  <= '0;
      end else if (run_go) begin
         rem    <= len;
         mode_q <= mode;
         acc    <= '0;
         ovf_q  <= '0;
      end else if (beat) begin
         rem    <= rem - LEN_W'(1);
         acc    <= sum;
         ovf_q  <= ovf_q | sum_ovf;
      end
   end

   // Outputs depend on registered state only.
   always_comb begin
      in_ready  = (state == ACC);
      out_valid = (state == OUT);
      busy      = (state != IDLE);
      out_data  = acc;
      ovf       = ovf_q;
   end

endmodule

// File: tb/tb_simd_acc32.sv
// Directed-vector bench for simd_acc32 (LEN_W = 8, SAT = 1).
module tb_simd_acc32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        mode;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  ovf;
   logic        busy;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   simd_acc32 #(.LEN_W(8), .SAT(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [7:0] l, input logic m);
      start = 1'b1; len = l; mode = m;
      tick();
      start = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d);
      in_valid = 1'b1; in_data = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      for (int i = 0; i < 20 && !out_valid; i++) tick();
      check(tag, {31'b0, out_valid}, 32'd1);
   endtask

   task automatic take(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check(tag, {31'b0, busy}, 32'd0);
   endtask

   logic [6:0] vpat;

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; mode = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      check("rst_out_data", out_data, 32'h0);
      check("rst_ctl", {27'b0, out_valid, in_ready, busy, ovf}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      check("idle_ctl", {27'b0, out_valid, in_ready, busy, ovf}, 32'h0);

      // mode 0 basic, latency
      go(8'd3, 1'b0);
      check("t1_in_ready", {31'b0, in_ready}, 32'd1);
      beat(32'h0001_0002);
      beat(32'h0001_0002);
      check("t1_not_yet", {31'b0, out_valid}, 32'd0);
      beat(32'h0001_0002);
      check("t1_latency", {31'b0, out_valid}, 32'd1);
      check("t1_data", out_data, 32'h0003_0006);
      check("t1_ovf", {30'b0, ovf}, 32'h0);
      take("t1_idle");

      // mode 0 saturation on both lanes
      go(8'd2, 1'b0);
      beat(32'h7000_8000);
      beat(32'h7000_8000);
      wait_out("t2_valid");
      check("t2_data", out_data, 32'h7FFF_8000);
      check("t2_ovf", {30'b0, ovf}, 32'h3);
      take("t2_idle");

      // mode 1 carry across lanes; len/mode changes mid-run ignored
      go(8'd2, 1'b1);
      len = 8'd1; mode = 1'b0;
      beat(32'h0000_FFFF);
      check("t3_len_latched", {31'b0, out_valid}, 32'd0);
      beat(32'h0000_0001);
      wait_out("t3_valid");
      check("t3_data", out_data, 32'h0001_0000);
      check("t3_ovf_cleared", {30'b0, ovf}, 32'h0);
      take("t3_idle");

      go(8'd2, 1'b0);
      beat(32'h0000_FFFF);
      beat(32'h0000_0001);
      wait_out("t3b_valid");
      check("t3b_data", out_data, 32'h0000_0000);
      check("t3b_ovf", {30'b0, ovf}, 32'h0);
      take("t3b_idle");

      // mode 1 per-beat saturation then back off
      go(8'd3, 1'b1);
      beat(32'h7FFF_FFFF);
      beat(32'h0000_0001);
      beat(32'hFFFF_FFFF);
      wait_out("t3c_valid");
      check("t3c_data", out_data, 32'h7FFF_FFFE);
      check("t3c_ovf", {30'b0, ovf}, 32'h1);
      take("t3c_idle");

      // gaps in in_valid, stalled output, ignored starts
      go(8'd4, 1'b0);
      vpat = 7'b1011001;
      for (int i = 0; i < 7; i++) begin
         in_valid = vpat[i];
         in_data  = 32'(i + 1);
         tick();
      end
      in_valid = 1'b1; in_data = 32'h0000_0100;
      for (int k = 0; k < 5; k++) begin
         start = (k == 1 || k == 3);
         len   = 8'd3;
         tick();
         check("t4_hold_data", out_data, 32'h0000_0011);
         check("t4_hold_ctl", {29'b0, out_valid, in_ready, busy}, 32'h5);
      end
      start = 1'b1; len = 8'd2; out_ready = 1'b1;
      tick();
      start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check("t4_hs_idle", {29'b0, out_valid, in_ready, busy}, 32'h0);
      tick();
      check("t4_start_ignored", {29'b0, out_valid, in_ready, busy}, 32'h0);

      // len 0 ignored
      go(8'd0, 1'b0);
      check("t5_len0", {29'b0, out_valid, in_ready, busy}, 32'h0);

      // full-length run
      go(8'd255, 1'b0);
      for (int i = 0; i < 254; i++) beat(32'h0001_0001);
      check("t5_254", {31'b0, out_valid}, 32'd0);
      beat(32'h0001_0001);
      check("t5_255_valid", {31'b0, out_valid}, 32'd1);
      check("t5_255_data", out_data, 32'h00FF_00FF);
      take("t5_idle");

      // reset mid-run
      go(8'd5, 1'b0);
      beat(32'h1111_1111);
      beat(32'h1111_1111);
      rst = 1'b1;
      #1;
      check("t6_rst_data", out_data, 32'h0);
      check("t6_rst_ctl", {27'b0, out_valid, in_ready, busy, ovf}, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      check("t6_after_rst", {29'b0, out_valid, in_ready, busy}, 32'h0);
      go(8'd1, 1'b0);
      beat(32'h1234_5678);
      wait_out("t6_valid");
      check("t6_data", out_data, 32'h1234_5678);
      take("t6_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
